ip_host_intf: RTL and testbench
===============================

# ip_host_intf

Slave-side host interface for a processing IP on the configuration bus. Decodes the 5-bit `conf_dbus` selector with single-cycle `read`/`write` strobes. Owns the IP's input memory, output memory, configuration registers, status/interrupt logic and ID register. Forwards `start` to the processing core and presents memories and config to it on a simple core-side port.

## Interface
- `IP_ID`, 32'h0000_1001: value returned on ID read.
- `DW`, 32: data width.
- `MIN_AW`, 4: input-memory address width (depth 2^MIN_AW).
- `MOUT_AW`, 4: output-memory address width.
- `CFG_AW`, 2: config register count is 2^CFG_AW.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `conf_dbus` in 5: register/memory selector.
- `data_in` in DW: host write data.
- `read` in 1: host read strobe.
- `write` in 1: host write strobe.
- `start` in 1: host start strobe.
- `data_out` out DW: host read data, registered.
- `int_n` out 1: active-low interrupt.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_min_addr` in MIN_AW: core input-memory read address.
- `core_min_data` out DW: input-memory data, 1-cycle read latency.
- `core_mout_we` in 1: core output-memory write enable.
- `core_mout_addr` in MOUT_AW: core output-memory write address.
- `core_mout_data` in DW: core output-memory write data.
- `core_cfg_sel` in CFG_AW: config register select.
- `core_cfg_data` out DW: selected config register, combinational.
- `core_flags_set` in 16: per-bit set pulses into the status flags.

## Operation
- Address map:
  - 0x00: MEMIN data, write-only.
  - 0x01: MEMIN pointer, R/W.
  - 0x02: MEMOUT data, read-only.
  - 0x03: MEMOUT pointer, R/W.
  - 0x04: CONFIG data, write-only.
  - 0x05: CONFIG pointer, R/W.
  - 0x1E: STATUS.
  - 0x1F: ID, read-only.
- Data writes (0x00, 0x04) store `data_in` at the current pointer, then post-increment it. Pointers are modulo their depth and wrap without error.
- MEMOUT data read (0x02):
  - returns the word at the MEMOUT pointer, then increments the pointer (same wrap rule);
  - pointer-write values are truncated to the pointer width.
- STATUS:
  - Read returns {mask[15:0], flags[15:0]}.
  - Write sets mask = `data_in[31:16]` and clears every flag whose `data_in[15:0]` bit is 1.
- Flags are set by `core_flags_set`. A set and a clear of the same bit in the same cycle leaves the bit set.
- `int_n` = ~|(flags & mask).
- Reads of unmapped selectors or write-only locations return 0 and have no side effects. Writes to unmapped or read-only selectors are ignored.
- `read` and `write` in the same cycle: the read is performed and the write is dropped.
- `start` registers to `core_start`. `start` held high N cycles produces N pulses; the bus protocol guarantees single-cycle strobes.

## Timing
- Reset values:
  - `data_out` = 0, `int_n` = 1, `core_start` = 0;
  - all pointers, flags and mask = 0;
  - config registers = 0;
  - memory contents are undefined.
- A write takes effect at the clock edge where `write` = 1. A pointer write followed immediately by a data write uses the new pointer.
- A read strobe at edge N produces valid `data_out` after edge N+1 (one-cycle latency). `data_out` is held until the next read.
- `core_start` is high exactly the cycle after `start` was sampled high.
- Flag set at edge N: `int_n` falls after edge N+1 (flags and `int_n` are both registered).
- Core MEMOUT write and host MEMOUT read to the same address in the same cycle: the host gets the old data.
- Reset asserted mid-operation clears all registers immediately (asynchronously). Strobes during reset are ignored.

## Structure
- Shared package `ip_host_pkg` holds:
  - the selector constants (`SEL_MIN_DATA` … `SEL_ID`);
  - the status field widths;
  - a `status_t` struct {mask, flags}.
- Sub-module `ip_sdp_ram`:
  - simple dual-port RAM, one write port, one registered read port, parameterised width/depth;
  - instantiated twice: for MEMIN (host writes, core reads) and for MEMOUT (core writes, host reads).
- Config registers are a flop array inside `ip_host_intf`.

## Test plan
- After reset, read 0x1F, then read 0x1E -> `data_out` = 32'h0000_1001, then 32'h0000_0000. `int_n` = 1 throughout.
- Write 0x01 = 0. Write 0x00 with 18 words (1..18). Read 0x01 -> 2. Drive `core_min_addr` 0 and 1 -> 17 and 18 (wrap overwrote); addr 2 -> 3.
- Core writes MEMOUT[0..3] = A0..A3. Write 0x03 = 0. Read 0x02 four times -> A0, A1, A2, A3, each one cycle after its strobe. Read 0x03 -> 4.
- Write 0x1E = {16'h0001, 16'h0000}. Pulse `core_flags_set` = 16'h0001 -> `int_n` low two edges later. Write 0x1E = {16'h0001, 16'h0001} in the same cycle as another set pulse -> flag stays set. Clear again -> `int_n` = 1.
- Config write 0x05 = 2, then 0x04 = DEADBEEF. Check `core_cfg_sel` = 2 -> DEADBEEF. Pulse `start` once -> `core_start` is a single pulse one cycle later.
- Assert `rst_n` low mid-burst (between MEMIN writes) -> pointers, flags and `data_out` are 0 immediately. `int_n` = 1. The first write after release lands at MEMIN[0].

Source files
------------

// File: rtl/ip_host_pkg.sv
// Shared definitions for the IP host interface: bus selector map,
// status register layout and field widths.
package ip_host_pkg;

  localparam int SEL_W = 5;

  localparam logic [SEL_W-1:0] SEL_MIN_DATA  = 5'h00;
  localparam logic [SEL_W-1:0] SEL_MIN_PTR   = 5'h01;
  localparam logic [SEL_W-1:0] SEL_MOUT_DATA = 5'h02;
  localparam logic [SEL_W-1:0] SEL_MOUT_PTR  = 5'h03;
  localparam logic [SEL_W-1:0] SEL_CFG_DATA  = 5'h04;
  localparam logic [SEL_W-1:0] SEL_CFG_PTR   = 5'h05;
  localparam logic [SEL_W-1:0] SEL_STATUS    = 5'h1E;
  localparam logic [SEL_W-1:0] SEL_ID        = 5'h1F;

  localparam int STAT_MASK_W = 16;
  localparam int STAT_FLAG_W = 16;

  // Status word as seen on the bus: mask in the upper half, flags below.
  typedef struct packed {
    logic [STAT_MASK_W-1:0] mask;
    logic [STAT_FLAG_W-1:0] flags;
  } status_t;

endpackage

// File: rtl/ip_host_intf_if.sv
// Host-side configuration bus bundle: selector, strobes, write data,
// registered read data and the active-low interrupt.
interface ip_host_intf_if
  import ip_host_pkg::*;
#(
  parameter int DW = 32
);
  logic [SEL_W-1:0] conf_dbus;
  logic [DW-1:0]    data_in;
  logic             read;
  logic             write;
  logic             start;
  logic [DW-1:0]    data_out;
  logic             int_n;

  modport master (
    output conf_dbus, data_in, read, write, start,
    input  data_out, int_n
  );

  modport slave (
    input  conf_dbus, data_in, read, write, start,
    output data_out, int_n
  );
endinterface

// File: rtl/ip_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module ip_sdp_ram #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Write port and read-before-write registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ip_host_intf.sv
// Slave-side host interface of the processing IP: decodes the config bus,
// owns input/output memories, config registers, status/interrupt and ID,
// and presents memories and config to the core.
module ip_host_intf
  import ip_host_pkg::*;
#(
  parameter logic [31:0] IP_ID   = 32'h0000_1001,
  parameter int          DW      = 32,
  parameter int          MIN_AW  = 4,
  parameter int          MOUT_AW = 4,
  parameter int          CFG_AW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ip_host_intf_if.slave          bus,
  output logic                   core_start,
  input  logic [MIN_AW-1:0]      core_min_addr,
  output logic [DW-1:0]          core_min_data,
  input  logic                   core_mout_we,
  input  logic [MOUT_AW-1:0]     core_mout_addr,
  input  logic [DW-1:0]          core_mout_data,
  input  logic [CFG_AW-1:0]      core_cfg_sel,
  output logic [DW-1:0]          core_cfg_data,
  input  logic [STAT_FLAG_W-1:0] core_flags_set
);

  localparam int CFG_N = 2**CFG_AW;

  logic [MIN_AW-1:0]      min_ptr;
  logic [MOUT_AW-1:0]     mout_ptr;
  logic [CFG_AW-1:0]      cfg_ptr;
  logic [DW-1:0]          cfg_q [CFG_N];
  status_t                stat;
  logic [STAT_FLAG_W-1:0] flags_clr;
  logic [STAT_FLAG_W-1:0] flags_nxt;
  logic                   int_n_q;

  logic rd_en, wr_en;
  logic min_we, min_ptr_we, mout_rd, mout_ptr_we, cfg_we, cfg_ptr_we, stat_we;
  logic [DW-1:0] mout_q;
  logic [DW-1:0] rd_mux;

  logic          rd_vld_p1;
  logic          rd_mout_p1;
  logic [DW-1:0] rd_word_p1;
  logic [DW-1:0] rd_data_p2;

  // A simultaneous read wins; the write is dropped.
  assign rd_en = bus.read;
  assign wr_en = bus.write & ~bus.read;

  assign min_we      = wr_en && (bus.conf_dbus == SEL_MIN_DATA);
  assign min_ptr_we  = wr_en && (bus.conf_dbus == SEL_MIN_PTR);
  assign mout_ptr_we = wr_en && (bus.conf_dbus == SEL_MOUT_PTR);
  assign cfg_we      = wr_en && (bus.conf_dbus == SEL_CFG_DATA);
  assign cfg_ptr_we  = wr_en && (bus.conf_dbus == SEL_CFG_PTR);
  assign stat_we     = wr_en && (bus.conf_dbus == SEL_STATUS);
  assign mout_rd     = rd_en && (bus.conf_dbus == SEL_MOUT_DATA);

  ip_sdp_ram #(.W(DW), .AW(MIN_AW)) u_memin (
    .clk   (clk),
    .we    (min_we),
    .waddr (min_ptr),
    .wdata (bus.data_in),
    .raddr (core_min_addr),
    .rdata (core_min_data)
  );

  ip_sdp_ram #(.W(DW), .AW(MOUT_AW)) u_memout (
    .clk   (clk),
    .we    (core_mout_we),
    .waddr (core_mout_addr),
    .wdata (core_mout_data),
    .raddr (mout_ptr),
    .rdata (mout_q)
  );

  // Memory/config pointers: explicit loads, post-increment on data access, natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_ptr  <= '0;
      mout_ptr <= '0;
      cfg_ptr  <= '0;
    end else begin
      if (min_ptr_we)       min_ptr  <= bus.data_in[MIN_AW-1:0];
      else if (min_we)      min_ptr  <= min_ptr + 1'b1;
      if (mout_ptr_we)      mout_ptr <= bus.data_in[MOUT_AW-1:0];
      else if (mout_rd)     mout_ptr <= mout_ptr + 1'b1;
      if (cfg_ptr_we)       cfg_ptr  <= bus.data_in[CFG_AW-1:0];
      else if (cfg_we)      cfg_ptr  <= cfg_ptr + 1'b1;
    end
  end

  // Config register file written through the config pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CFG_N; i++) cfg_q[i] <= '0;
    end else if (cfg_we) begin
      cfg_q[cfg_ptr] <= bus.data_in;
    end
  end

  assign core_cfg_data = cfg_q[core_cfg_sel];

  // A core set pulse overrides a host clear of the same bit.
  assign flags_clr = stat_we ? bus.data_in[STAT_FLAG_W-1:0] : '0;
  assign flags_nxt = (stat.flags & ~flags_clr) | core_flags_set;

  // Status flags and mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat <= '0;
    end else begin
      stat.flags <= flags_nxt;
      if (stat_we) stat.mask <= bus.data_in[STAT_FLAG_W +: STAT_MASK_W];
    end
  end

  // Registered interrupt and start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_n_q    <= 1'b1;
      core_start <= 1'b0;
    end else begin
      int_n_q    <= ~|(stat.flags & stat.mask);
      core_start <= bus.start;
    end
  end

  // Read mux for register-backed locations; write-only and unmapped read as 0.
  always_comb begin
    rd_mux = '0;
    case (bus.conf_dbus)
      SEL_MIN_PTR:  rd_mux = DW'(min_ptr);
      SEL_MOUT_PTR: rd_mux = DW'(mout_ptr);
      SEL_CFG_PTR:  rd_mux = DW'(cfg_ptr);
      SEL_STATUS:   rd_mux = DW'(stat);
      SEL_ID:       rd_mux = DW'(IP_ID);
      default:      rd_mux = '0;
    endcase
  end

  // Stage p1: capture the read strobe and register-backed word alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1  <= 1'b0;
      rd_mout_p1 <= 1'b0;
      rd_word_p1 <= '0;
    end else begin
      rd_vld_p1  <= rd_en;
      rd_mout_p1 <= mout_rd;
      rd_word_p1 <= rd_mux;
    end
  end

  // Stage p2: update host read data, held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p2 <= '0;
    end else if (rd_vld_p1) begin
      rd_data_p2 <= rd_mout_p1 ? mout_q : rd_word_p1;
    end
  end

  assign bus.data_out = rd_data_p2;
  assign bus.int_n    = int_n_q;

endmodule

// File: tb/tb_ip_host_intf.sv
// Bench for ip_host_intf: table of bus vectors plus hand sequences for
// memories, status/interrupt, config, start and asynchronous reset.
module tb_ip_host_intf;
  import ip_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_start;
  logic [3:0]  core_min_addr;
  logic [31:0] core_min_data;
  logic        core_mout_we;
  logic [3:0]  core_mout_addr;
  logic [31:0] core_mout_data;
  logic [1:0]  core_cfg_sel;
  logic [31:0] core_cfg_data;
  logic [15:0] core_flags_set;

  ip_host_intf_if #(.DW(32)) bus ();

  ip_host_intf dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .core_start     (core_start),
    .core_min_addr  (core_min_addr),
    .core_min_data  (core_min_data),
    .core_mout_we   (core_mout_we),
    .core_mout_addr (core_mout_addr),
    .core_mout_data (core_mout_data),
    .core_cfg_sel   (core_cfg_sel),
    .core_cfg_data  (core_cfg_data),
    .core_flags_set (core_flags_set)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          is_wr;
    logic [4:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-strobe tracker: data_out is due one edge after the edge that sampled read.
  logic rd_s1, rd_s2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1 <= 1'b0;
      rd_s2 <= 1'b0;
    end else begin
      rd_s1 <= bus.read;
      rd_s2 <= rd_s1;
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rd_s2) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_read", bus.data_out, 32'hxxxx_xxxx);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check(e.name, bus.data_out, e.exp);
      end
    end
  end

  task automatic bus_write(input logic [4:0] sel, input logic [31:0] d);
    bus.conf_dbus = sel;
    bus.data_in   = d;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] sel, input logic [31:0] exp, input string name);
    sb_t e;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    bus.conf_dbus = sel;
    bus.read      = 1'b1;
    @(negedge clk);
    bus.read      = 1'b0;
  endtask

  task automatic core_wr(input logic [3:0] a, input logic [31:0] d);
    core_mout_we   = 1'b1;
    core_mout_addr = a;
    core_mout_data = d;
    @(negedge clk);
    core_mout_we   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, SEL_ID,        32'h0,         32'h0000_1001, "id_read"};
    vecs[1]  = '{0, SEL_STATUS,    32'h0,         32'h0000_0000, "status_reset"};
    vecs[2]  = '{0, SEL_MIN_DATA,  32'h0,         32'h0000_0000, "memin_data_wo"};
    vecs[3]  = '{0, SEL_CFG_DATA,  32'h0,         32'h0000_0000, "cfg_data_wo"};
    vecs[4]  = '{0, 5'h13,         32'h0,         32'h0000_0000, "unmapped_read"};
    vecs[5]  = '{1, SEL_CFG_PTR,   32'h3,         32'h0,         ""};
    vecs[6]  = '{0, SEL_CFG_PTR,   32'h0,         32'h0000_0003, "cfg_ptr"};
    vecs[7]  = '{1, SEL_CFG_PTR,   32'hFFFF_FFF6, 32'h0,         ""};
    vecs[8]  = '{0, SEL_CFG_PTR,   32'h0,         32'h0000_0002, "cfg_ptr_trunc"};
    vecs[9]  = '{1, SEL_MOUT_PTR,  32'h25,        32'h0,         ""};
    vecs[10] = '{0, SEL_MOUT_PTR,  32'h0,         32'h0000_0005, "mout_ptr_trunc"};
    vecs[11] = '{1, SEL_MIN_PTR,   32'h1A,        32'h0,         ""};
    vecs[12] = '{0, SEL_MIN_PTR,   32'h0,         32'h0000_000A, "min_ptr_trunc"};
    vecs[13] = '{1, SEL_ID,        32'h1234_5678, 32'h0,         ""};
    vecs[14] = '{1, SEL_MOUT_DATA, 32'h77,        32'h0,         ""};
    vecs[15] = '{0, SEL_MOUT_PTR,  32'h0,         32'h0000_0005, "mout_ptr_after_ro_write"};

    rst_n = 1'b0;
    bus.conf_dbus = '0; bus.data_in = '0; bus.read = 1'b0; bus.write = 1'b0; bus.start = 1'b0;
    core_min_addr = '0; core_mout_we = 1'b0; core_mout_addr = '0; core_mout_data = '0;
    core_cfg_sel = '0; core_flags_set = '0;
    idle(2);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_int_n", {31'h0, bus.int_n}, 32'h1);
    check("rst_core_start", {31'h0, core_start}, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Table-driven register map vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].sel, vecs[i].data);
      else               bus_read(vecs[i].sel, vecs[i].exp, vecs[i].name);
    end
    bus_read(SEL_ID, 32'h0000_1001, "id_after_write");
    idle(4);
    check("data_out_hold", bus.data_out, 32'h0000_1001);
    check("int_n_idle", {31'h0, bus.int_n}, 32'h1);

    // MEMIN burst with wrap
    bus_write(SEL_MIN_PTR, 32'h0);
    for (int i = 1; i <= 18; i++) bus_write(SEL_MIN_DATA, i);
    bus_read(SEL_MIN_PTR, 32'h2, "min_ptr_wrap");
    core_min_addr = 4'd0; idle(1); check("memin0", core_min_data, 32'd17);
    core_min_addr = 4'd1; idle(1); check("memin1", core_min_data, 32'd18);
    core_min_addr = 4'd2; idle(1); check("memin2", core_min_data, 32'd3);

    // MEMOUT core writes, back-to-back host reads, same-address collision
    for (int i = 0; i < 4; i++) core_wr(i[3:0], 32'hA0A0_0000 + i);
    core_wr(4'd4, 32'hB0B0_0000);
    bus_write(SEL_MOUT_PTR, 32'h0);
    for (int i = 0; i < 4; i++) bus_read(SEL_MOUT_DATA, 32'hA0A0_0000 + i, "memout_rd");
    bus_read(SEL_MOUT_PTR, 32'h4, "mout_ptr_inc");
    sb_q.push_back('{32'hB0B0_0000, "memout_collision_old"});
    bus.conf_dbus = SEL_MOUT_DATA; bus.read = 1'b1;
    core_mout_we = 1'b1; core_mout_addr = 4'd4; core_mout_data = 32'hB1B1_0000;
    @(negedge clk);
    bus.read = 1'b0; core_mout_we = 1'b0;
    bus_read(SEL_MOUT_PTR, 32'h5, "mout_ptr_after_collision");
    bus_write(SEL_MOUT_PTR, 32'h4);
    bus_read(SEL_MOUT_DATA, 32'hB1B1_0000, "memout_new");
    idle(3);

    // Status / interrupt
    bus_write(SEL_STATUS, 32'h0001_0000);
    core_flags_set = 16'h0001;
    @(negedge clk);
    core_flags_set = 16'h0000;
    check("int_n_after_1_edge", {31'h0, bus.int_n}, 32'h1);
    @(negedge clk);
    check("int_n_after_2_edges", {31'h0, bus.int_n}, 32'h0);
    bus_read(SEL_STATUS, 32'h0001_0001, "status_flag_set");
    bus.conf_dbus = SEL_STATUS; bus.data_in = 32'h0001_0001; bus.write = 1'b1;
    core_flags_set = 16'h0001;
    @(negedge clk);
    bus.write = 1'b0; core_flags_set = 16'h0000;
    bus_read(SEL_STATUS, 32'h0001_0001, "status_set_beats_clear");
    check("int_n_held", {31'h0, bus.int_n}, 32'h0);
    bus_write(SEL_STATUS, 32'h0001_0001);
    idle(2);
    check("int_n_cleared", {31'h0, bus.int_n}, 32'h1);
    core_flags_set = 16'h0002;
    @(negedge clk);
    core_flags_set = 16'h0000;
    idle(2);
    check("int_n_masked", {31'h0, bus.int_n}, 32'h1);
    bus_read(SEL_STATUS, 32'h0001_0002, "status_masked_flag");
    bus_write(SEL_STATUS, 32'h0000_0002);
    bus_read(SEL_STATUS, 32'h0000_0000, "status_all_clear");

    // Config and start
    bus_write(SEL_CFG_PTR, 32'h2);
    bus_write(SEL_CFG_DATA, 32'hDEAD_BEEF);
    core_cfg_sel = 2'd2; #1 check("cfg2", core_cfg_data, 32'hDEAD_BEEF);
    core_cfg_sel = 2'd3; #1 check("cfg3_reset", core_cfg_data, 32'h0);
    @(negedge clk);
    sb_q.push_back('{32'h3, "rd_wins_over_wr"});
    bus.conf_dbus = SEL_CFG_PTR; bus.data_in = 32'h1; bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
    bus_read(SEL_CFG_PTR, 32'h3, "wr_dropped");
    bus.start = 1'b1;
    check("core_start_pre", {31'h0, core_start}, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    check("core_start_pulse", {31'h0, core_start}, 32'h1);
    @(negedge clk);
    check("core_start_single", {31'h0, core_start}, 32'h0);
    idle(3);

    // Asynchronous reset in the middle of a MEMIN burst
    bus_write(SEL_STATUS, 32'h0004_0000);
    core_flags_set = 16'h0004;
    @(negedge clk);
    core_flags_set = 16'h0000;
    bus_read(SEL_ID, 32'h0000_1001, "id_before_reset");
    bus_write(SEL_MIN_PTR, 32'h5);
    bus_write(SEL_MIN_DATA, 32'h11);
    bus_write(SEL_MIN_DATA, 32'h22);
    idle(2);
    check("int_n_before_reset", {31'h0, bus.int_n}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data_out", bus.data_out, 32'h0);
    check("arst_int_n", {31'h0, bus.int_n}, 32'h1);
    bus.conf_dbus = SEL_MIN_PTR; bus.data_in = 32'h7; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    rst_n = 1'b1;
    bus_read(SEL_MIN_PTR, 32'h0, "arst_min_ptr");
    bus_read(SEL_MOUT_PTR, 32'h0, "arst_mout_ptr");
    bus_read(SEL_CFG_PTR, 32'h0, "arst_cfg_ptr");
    bus_read(SEL_STATUS, 32'h0, "arst_status");
    bus_write(SEL_MIN_DATA, 32'h55);
    core_min_addr = 4'd0; idle(1); check("arst_first_write", core_min_data, 32'h55);
    core_cfg_sel = 2'd2; #1 check("arst_cfg2", core_cfg_data, 32'h0);
    idle(4);

    check("sb_drain", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
